fb_scanout_arbiter: RTL
=======================

Name: fb_scanout_arbiter

Overview:
- Owns a single-port low-resolution framebuffer (block RAM) and shares it between two users: the pixel scanout path and a pixel-write requester.
- Sits between signal_720p and rgb2dvi_0, replacing the procedural painter.
- Scanout has hard priority on fixed slots. Writes and a hardware clear sequencer use all remaining cycles.
- Each framebuffer pixel is upscaled by 2^SCALE_LOG2 in both axes.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 90, framebuffer height in pixels.
- SCALE_LOG2, 3, log2 of the upscale factor (1280/160 = 8).
- CLEAR_COLOR, 12'h000, RGB444 value written by the clear sequence.

Ports:
- clk_pix  in  1  pixel clock
- rst_pix_n  in  1  asynchronous active-low reset
- sx  in  11  horizontal position from the timing generator
- sy  in  11  vertical position from the timing generator
- de_in  in  1  data enable from the timing generator
- hsync_in  in  1  hsync from the timing generator
- vsync_in  in  1  vsync from the timing generator
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when high with wr_valid
- wr_x  in  8  framebuffer x coordinate
- wr_y  in  7  framebuffer y coordinate
- wr_data  in  12  RGB444 pixel, {r[3:0], g[3:0], b[3:0]}
- clear_req  in  1  single-cycle pulse that starts a full-framebuffer clear
- clear_busy  out  1  clear sequence in progress
- wr_drop_cnt  out  16  count of accepted out-of-range writes, saturating
- rgb_r  out  8  red to TMDS encoder
- rgb_g  out  8  green to TMDS encoder
- rgb_b  out  8  blue to TMDS encoder
- de  out  1  delayed data enable
- hsync  out  1  delayed hsync
- vsync  out  1  delayed vsync

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled at top):
  - All registered outputs are 0: rgb_*, de, hsync, vsync, clear_busy, wr_drop_cnt.
  - FSM goes to IDLE. RAM contents are undefined.
  - wr_ready = 0 while rst_pix_n = 0.
- Scan slot: scan_slot = de_in & (sx[SCALE_LOG2-1:0] == 0).
  - On a scan slot the RAM reads address (sy>>SCALE_LOG2)*FB_W + (sx>>SCALE_LOG2).
  - RAM read latency is 1 cycle. The read word is held in a pixel register until the next scan slot.
- Output latency:
  - de, hsync and vsync equal de_in, hsync_in and vsync_in delayed exactly 2 cycles.
  - rgb_* is registered and aligned with the delayed de. Each channel expands 4 bits to 8 by nibble replication ({n,n}).
  - rgb_* = 0 whenever the delayed de = 0.
- Arbitration: one RAM access per cycle; scanout always wins.
  - wr_ready = rst_pix_n & ~scan_slot & (state == IDLE). It is combinational from inputs and state, with no dependence on wr_valid.
  - A write is performed in the same cycle it is accepted (wr_valid & wr_ready).
- Range check:
  - An accepted write with wr_x >= FB_W or wr_y >= FB_H does not touch the RAM.
  - It increments wr_drop_cnt, which saturates at 16'hFFFF.
- FSM states:
  - IDLE: clear_req = 1 moves to CLEAR. The clear counter is set to 0 and clear_busy goes high the next cycle.
  - CLEAR: on every non-scan-slot cycle, write CLEAR_COLOR at the counter address and increment the counter.
  - CLEAR: when a write occurs at address FB_W*FB_H-1, move to IDLE and drop clear_busy the next cycle.
  - CLEAR: scan slots stall the counter.
- Simultaneous events:
  - clear_req in CLEAR is ignored.
  - If clear_req and wr_valid arrive in the same IDLE cycle, the write is accepted (wr_ready is high), and CLEAR is entered the next cycle.
  - Reset mid-clear returns the FSM to IDLE immediately. Partially cleared RAM is acceptable.
- Width rules:
  - The address is 14 bits; FB_W*FB_H must be <= 16384, checked by an elaboration assertion.
  - The multiply by FB_W is a constant multiply.

Decomposition:
- Package fb_pkg holds:
  - the RGB444 pixel typedef and the FSM state enum (IDLE, CLEAR);
  - FB_ADDR_W = 14;
  - the rgb444-to-rgb888 expansion function.
- Sub-module fb_ram: single-port synchronous RAM with en, we, 14-bit addr, 12-bit wdata and 1-cycle rdata, inferred as BRAM.

Test Plan:
1. Assert rst_pix_n=0 for 5 cycles with timing running. Required: rgb_*, de, hsync, vsync, clear_busy and wr_drop_cnt are all 0, and wr_ready=0. After release, wr_ready=1 during blanking.
2. During vertical blanking write (x=3, y=2, data=12'hF0A), then run the frame. Required: at output lines sy=16..23 and columns sx=24..31, rgb = (FF, 00, AA); adjacent columns show the prior contents. Output de/hsync/vsync lag the inputs by exactly 2 cycles.
3. Hold wr_valid=1 across an active line with sweeping coordinates. Required: wr_ready=0 exactly on the 160 cycles with sx[2:0]==0 and high otherwise, so 1120 writes are accepted per line. Scanned pixels are uncorrupted.
4. Pulse clear_req at the start of vertical blanking. Required: clear_busy high for exactly 14400 cycles, with wr_ready=0 throughout. The next frame is entirely CLEAR_COLOR.
5. Accepted writes at (160, 0) and (0, 90). Required: wr_drop_cnt goes 0→1→2 and the RAM is unchanged. After forcing the count to 16'hFFFE and doing 3 drops, the count reads 16'hFFFF.
6. Assert reset 100 cycles into a clear. Required: clear_busy=0 immediately after reset. After release, state is IDLE and a new clear_req restarts from address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer scanout arbiter.
package fb_pkg;

  localparam int FB_ADDR_W = 14;

  typedef logic [11:0] rgb444_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Each 4-bit channel is widened by nibble replication so 4'hF maps to 8'hFF.
  function automatic logic [23:0] rgb444_to_888(input rgb444_t p);
    return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port synchronous framebuffer RAM, one-cycle read latency, BRAM style.
module fb_ram
  import fb_pkg::*;
#(
  parameter int DEPTH = 14400
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [FB_ADDR_W-1:0] addr,
  input  logic [11:0]          wdata,
  output logic [11:0]          rdata
);

  rgb444_t mem [DEPTH];
  rgb444_t rdata_q;

  // Storage array with registered read port; read word holds on write cycles
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Shares one framebuffer RAM between upscaled pixel scanout (fixed priority
// slots), a pixel-write port and a hardware clear sequencer.
module fb_scanout_arbiter
  import fb_pkg::*;
#(
  parameter int          FB_W        = 160,
  parameter int          FB_H        = 90,
  parameter int          SCALE_LOG2  = 3,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic        clk_pix,
  input  logic        rst_pix_n,
  input  logic [10:0] sx,
  input  logic [10:0] sy,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_data,
  input  logic        clear_req,
  output logic        clear_busy,
  output logic [15:0] wr_drop_cnt,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        de,
  output logic        hsync,
  output logic        vsync
);

  localparam int                   FB_SIZE   = FB_W * FB_H;
  localparam logic [FB_ADDR_W-1:0] FB_W_A    = FB_ADDR_W'(FB_W);
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_SIZE - 1);
  localparam logic [7:0]           FB_W_X    = 8'(FB_W);
  localparam logic [6:0]           FB_H_Y    = 7'(FB_H);

  if (FB_SIZE > (1 << FB_ADDR_W)) begin : g_size_check
    $error("fb_scanout_arbiter: FB_W*FB_H exceeds the 14-bit address space");
  end

  fb_state_e            state_q, state_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 clear_busy_q, clear_busy_d;
  logic                 slot_q, slot_d;
  logic                 de_p1_q, de_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic                 de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  rgb444_t              pix_q, pix_d;
  logic [23:0]          rgb_q, rgb_d;

  logic                 scan_slot;
  logic [FB_ADDR_W-1:0] scan_addr;
  logic [FB_ADDR_W-1:0] wr_addr;
  logic                 wr_in_range;
  logic                 wr_fire;

  logic                 ram_en;
  logic                 ram_we;
  logic [FB_ADDR_W-1:0] ram_addr;
  rgb444_t              ram_wdata;
  rgb444_t              ram_rdata;

  // One scan slot per upscaled pixel: the first pixel-clock of each 2^SCALE_LOG2 group.
  assign scan_slot   = de_in & (sx[SCALE_LOG2-1:0] == {SCALE_LOG2{1'b0}});
  assign scan_addr   = FB_ADDR_W'(sy >> SCALE_LOG2) * FB_W_A + FB_ADDR_W'(sx >> SCALE_LOG2);
  assign wr_addr     = FB_ADDR_W'(wr_y) * FB_W_A + FB_ADDR_W'(wr_x);
  assign wr_in_range = (wr_x < FB_W_X) & (wr_y < FB_H_Y);
  assign wr_ready    = rst_pix_n & ~scan_slot & (state_q == IDLE);
  assign wr_fire     = wr_valid & wr_ready;

  // RAM port arbitration, clear sequencer and drop counter next-state
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = scan_addr;
    ram_wdata  = wr_data;

    if (scan_slot) begin
      ram_en = 1'b1;
    end else if (state_q == CLEAR) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_q;
      ram_wdata = CLEAR_COLOR;
    end else if (wr_fire && wr_in_range) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_addr;
    end else begin
      ram_en = 1'b0;
    end

    if (wr_fire && !wr_in_range && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = {FB_ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (scan_slot) begin
          clr_cnt_d = clr_cnt_q;
        end else if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + {{(FB_ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    clear_busy_d = (state_d == CLEAR);
  end

  // Two-stage output pipeline; the pixel register holds between scan slots
  always_comb begin
    slot_d  = scan_slot;
    de_p1_d = de_in;
    hs_p1_d = hsync_in;
    vs_p1_d = vsync_in;
    de_d    = de_p1_q;
    hs_d    = hs_p1_q;
    vs_d    = vs_p1_q;
    pix_d   = slot_q ? ram_rdata : pix_q;
    if (de_p1_q) begin
      rgb_d = rgb444_to_888(pix_d);
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // State and output registers
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q      <= IDLE;
      clr_cnt_q    <= {FB_ADDR_W{1'b0}};
      drop_cnt_q   <= 16'h0000;
      clear_busy_q <= 1'b0;
      slot_q       <= 1'b0;
      de_p1_q      <= 1'b0;
      hs_p1_q      <= 1'b0;
      vs_p1_q      <= 1'b0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      pix_q        <= 12'h000;
      rgb_q        <= 24'h000000;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      clear_busy_q <= clear_busy_d;
      slot_q       <= slot_d;
      de_p1_q      <= de_p1_d;
      hs_p1_q      <= hs_p1_d;
      vs_p1_q      <= vs_p1_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      pix_q        <= pix_d;
      rgb_q        <= rgb_d;
    end
  end

  fb_ram #(
    .DEPTH(FB_SIZE)
  ) u_ram (
    .clk  (clk_pix),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign clear_busy  = clear_busy_q;
  assign wr_drop_cnt = drop_cnt_q;
  assign rgb_r       = rgb_q[23:16];
  assign rgb_g       = rgb_q[15:8];
  assign rgb_b       = rgb_q[7:0];
  assign de          = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;

endmodule
